// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, one bit per clock, with a final sign/exception fix-up cycle.
module multdiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_100mhz,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic             abort,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             ready,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               is_div;
    logic               neg;
    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH:0]     mag_b;

    logic               start_ok;
    logic [WIDTH:0]     ext_a, ext_b, mag_a_in, mag_b_in;
    logic [WIDTH:0]     mul_sum, div_shift, div_rem;
    logic               div_ge;
    logic [WIDTH:0]     hi_next;
    logic [WIDTH-1:0]   lo_next;
    logic [2*WIDTH-1:0] prod, prod_signed;
    logic [WIDTH:0]     prod_top;
    logic [WIDTH-1:0]   quot_signed;
    logic [WIDTH-1:0]   fix_result;
    logic               fix_exc;

    // Magnitudes are formed one bit wider so that |-2^(WIDTH-1)| does not wrap.
    always_comb begin
        start_ok = (ctrl_mult ^ ctrl_div) && !abort && (state == IDLE || state == DONE);
        ext_a    = {operand_a[WIDTH-1], operand_a};
        ext_b    = {operand_b[WIDTH-1], operand_b};
        mag_a_in = operand_a[WIDTH-1] ? -ext_a : ext_a;
        mag_b_in = operand_b[WIDTH-1] ? -ext_b : ext_b;

        mul_sum   = acc_hi + (acc_lo[0] ? mag_b : '0);
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_ge    = div_shift >= mag_b;
        div_rem   = div_ge ? div_shift - mag_b : div_shift;

        if (is_div) begin
            hi_next = div_rem;
            lo_next = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            hi_next = {1'b0, mul_sum[WIDTH:1]};
            lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end

        prod        = {acc_hi[WIDTH-1:0], acc_lo};
        prod_signed = neg ? -prod : prod;
        prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
        quot_signed = neg ? -acc_lo : acc_lo;

        // A positive quotient with its top bit set can only be 2^(WIDTH-1): the MIN / -1 case.
        if (is_div) begin
            if (mag_b == '0) begin
                fix_result = '0;
                fix_exc    = 1'b1;
            end else begin
                fix_result = quot_signed;
                fix_exc    = acc_lo[WIDTH-1] && !neg;
            end
        end else begin
            fix_result = prod_signed[WIDTH-1:0];
            fix_exc    = (prod_top != '0) && (prod_top != '1);
        end
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            is_div    <= 1'b0;
            neg       <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            mag_b     <= '0;
            result    <= '0;
            exception <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state             <= RUN;
                        busy              <= 1'b1;
                        count             <= '0;
                        is_div            <= ctrl_div;
                        neg               <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        {acc_hi, acc_lo}  <= {{WIDTH{1'b0}}, mag_a_in};
                        mag_b             <= mag_b_in;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc_hi <= hi_next;
                        acc_lo <= lo_next;
                        if (count == CNT_W'(WIDTH - 1))
                            state <= FIX;
                        else
                            count <= count + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        result    <= fix_result;
                        exception <= fix_exc;
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
